arb_mux_reg: RTL



---
 rtl/mux_pkg.sv | 12 +
 rtl/arb_mux_reg_if.sv | 40 ++++
 rtl/rr_grant.sv | 43 ++++
 rtl/arb_mux_reg.sv | 80 ++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating mux family.
// Mode constants and select-width helper.
package mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Handshake bundle for arb_mux_reg.
// master drives the sources and sink-ready; slave is the mux.
interface arb_mux_reg_if
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4
);

   localparam int SEL_W = sel_width(N_IN);

   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_sel;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_data,
      input  out_valid,
      input  out_sel
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_data,
      output out_valid,
      output out_sel
   );

endinterface

// File: rtl/rr_grant.sv
// One-hot grant plus encoded index from a request vector.
// Round-robin search starts at ptr; fixed mode starts at 0.
module rr_grant
   import mux_pkg::*;
#(
   parameter int N_IN = 4,
   parameter int MODE = MODE_FIXED,
   localparam int SEL_W = sel_width(N_IN)
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_IN-1:0]  grant,
   output logic [SEL_W-1:0] idx
);

   logic [2*N_IN-1:0] mask;
   logic [2*N_IN-1:0] hit;
   logic              found;
   int                base;

   // Lower copy masked below ptr, upper copy open: wraps the search.
   always_comb begin
      mask = '1;
      base = (MODE == MODE_RR) ? int'(ptr) : 0;
      for (int j = 0; j < N_IN; j++)
         mask[j] = (j >= base);
      hit = {req, req} & mask;
   end

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int j = 0; j < 2*N_IN; j++) begin
         if (hit[j] && !found) begin
            found             = 1'b1;
            grant[j % N_IN]   = 1'b1;
            idx               = SEL_W'(j % N_IN);
         end
      end
   end

endmodule

// File: rtl/arb_mux_reg.sv
// N-input arbitrating mux with a one-entry registered output.
// Fixed-priority or round-robin grant; reload on drain, no bubble.
module arb_mux_reg
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int MODE  = MODE_FIXED
) (
   input logic         clk,
   input logic         rst_n,
   arb_mux_reg_if.slave bus
);

   localparam int SEL_W = sel_width(N_IN);

   logic [N_IN-1:0]  req;
   logic [N_IN-1:0]  grant;
   logic [SEL_W-1:0] gidx;
   logic [SEL_W-1:0] rr_ptr;
   logic             load;
   logic             take;
   logic [WIDTH-1:0] mux_data;
   logic [WIDTH-1:0] data_q;
   logic [SEL_W-1:0] sel_q;
   logic             valid_q;

   // Grant is forced off while reset is held.
   assign req = rst_n ? bus.in_valid : '0;

   rr_grant #(
      .N_IN (N_IN),
      .MODE (MODE)
   ) u_grant (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx)
   );

   assign load        = !valid_q || bus.out_ready;
   assign bus.in_ready = grant & {N_IN{load}};
   assign take        = |bus.in_ready;

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N_IN; i++)
         mux_data |= bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sel_q   <= '0;
      end else if (take) begin
         valid_q <= 1'b1;
         data_q  <= mux_data;
         sel_q   <= gidx;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (take && MODE == MODE_RR) begin
         if (int'(gidx) == N_IN - 1)
            rr_ptr <= '0;
         else
            rr_ptr <= gidx + SEL_W'(1);
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.out_sel   = sel_q;

endmodule
